// File: rtl/turn_request_if.sv
// Switch/sequencer-side signal bundle for the turn request controller.
// The controller attaches through the slave modport.
interface turn_request_if #(
  parameter int unsigned CNT_W = 5
) ();
  logic             left_sw;
  logic             right_sw;
  logic             seq_idle;
  logic             left;
  logic             right;
  logic [1:0]       mode;
  logic [CNT_W-1:0] blink_cnt;
  logic             busy;

  modport master (
    output left_sw, right_sw, seq_idle,
    input  left, right, mode, blink_cnt, busy
  );

  modport slave (
    input  left_sw, right_sw, seq_idle,
    output left, right, mode, blink_cnt, busy
  );
endinterface

// File: rtl/turn_request_ctrl.sv
// Turn-stalk front end: synchronises and debounces both switches, classifies
// tap/hold, and drives clean left/right request levels to the taillight sequencer.
module turn_request_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TAP_MAX_CYCLES  = 16,
  parameter int unsigned LANE_BLINKS     = 3,
  parameter int unsigned CNT_W           = 5
) (
  input  logic          div_clk,
  input  logic          rst,
  turn_request_if.slave tr
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CNT_X = CNT_W + 1;
  localparam logic [CNT_X-1:0] LANE_N = CNT_X'(LANE_BLINKS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRESS_L = 3'd1,
    S_HOLD_L  = 3'd2,
    S_LANE_L  = 3'd3,
    S_PRESS_R = 3'd4,
    S_HOLD_R  = 3'd5,
    S_LANE_R  = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sync1_q, sync2_q;
  logic [1:0]             deb_q, deb_d;
  logic [1:0][DB_W-1:0]   dcnt_q, dcnt_d;
  logic [CNT_W-1:0]       hold_q, hold_d;
  logic [CNT_W-1:0]       blink_q, blink_d;
  logic [CNT_W-1:0]       blink_sat;
  logic [CNT_X-1:0]       blink_inc;
  logic                   prev_idle_q;
  logic                   start;
  logic                   side_r, own, oth;
  logic                   left_q, left_d;
  logic                   right_q, right_d;
  logic                   busy_q, busy_d;
  logic [1:0]             mode_q, mode_d;

  // Index 0 is the left stalk, index 1 the right stalk.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        dcnt_d[i] = '0;
      end else if (dcnt_q[i] + DB_W'(1) == DB_W'(DEBOUNCE_CYCLES)) begin
        deb_d[i]  = sync2_q[i];
        dcnt_d[i] = '0;
      end else begin
        dcnt_d[i] = dcnt_q[i] + DB_W'(1);
      end
    end
  end

  // A sequence has started when the sequencer leaves idle.
  assign start     = prev_idle_q & ~tr.seq_idle;
  assign side_r    = (state_q == S_PRESS_R) || (state_q == S_HOLD_R) || (state_q == S_LANE_R);
  assign own       = side_r ? deb_q[1] : deb_q[0];
  assign oth       = side_r ? deb_q[0] : deb_q[1];
  assign blink_sat = (&blink_q) ? blink_q : blink_q + CNT_W'(1);
  assign blink_inc = {1'b0, blink_q} + CNT_X'(1);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    blink_d = blink_q;
    if ((state_q != S_IDLE) && start) begin
      blink_d = blink_sat;
    end
    unique case (state_q)
      S_IDLE: begin
        if (deb_q[0] && !deb_q[1]) begin
          state_d = S_PRESS_L;
          hold_d  = '0;
          blink_d = '0;
        end else if (deb_q[1] && !deb_q[0]) begin
          state_d = S_PRESS_R;
          hold_d  = '0;
          blink_d = '0;
        end
      end
      S_PRESS_L, S_PRESS_R: begin
        if (oth) begin
          state_d = S_IDLE;
        end else if (!own) begin
          state_d = side_r ? S_LANE_R : S_LANE_L;
        end else begin
          hold_d = hold_q + CNT_W'(1);
          if (hold_d == CNT_W'(TAP_MAX_CYCLES)) begin
            state_d = side_r ? S_HOLD_R : S_HOLD_L;
          end
        end
      end
      S_HOLD_L, S_HOLD_R: begin
        if (oth || !own) begin
          state_d = S_IDLE;
        end
      end
      S_LANE_L, S_LANE_R: begin
        // Re-pressing the same stalk re-arms a fresh request.
        if (oth) begin
          state_d = S_IDLE;
        end else if (own) begin
          state_d = side_r ? S_PRESS_R : S_PRESS_L;
          hold_d  = '0;
          blink_d = '0;
        end else if ((start && (blink_inc >= LANE_N)) || ({1'b0, blink_q} >= LANE_N)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output levels are decoded from the next state and registered alongside it.
  always_comb begin
    left_d  = (state_d == S_PRESS_L) || (state_d == S_HOLD_L) || (state_d == S_LANE_L);
    right_d = (state_d == S_PRESS_R) || (state_d == S_HOLD_R) || (state_d == S_LANE_R);
    busy_d  = left_d | right_d;
    mode_d  = 2'b00;
    case (state_d)
      S_PRESS_L, S_PRESS_R: mode_d = 2'b01;
      S_HOLD_L,  S_HOLD_R:  mode_d = 2'b10;
      S_LANE_L,  S_LANE_R:  mode_d = 2'b11;
      default:              mode_d = 2'b00;
    endcase
  end

  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      dcnt_q      <= '0;
      hold_q      <= '0;
      blink_q     <= '0;
      prev_idle_q <= 1'b0;
      state_q     <= S_IDLE;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      busy_q      <= 1'b0;
      mode_q      <= 2'b00;
    end else begin
      sync1_q     <= {tr.right_sw, tr.left_sw};
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      dcnt_q      <= dcnt_d;
      hold_q      <= hold_d;
      blink_q     <= blink_d;
      prev_idle_q <= tr.seq_idle;
      state_q     <= state_d;
      left_q      <= left_d;
      right_q     <= right_d;
      busy_q      <= busy_d;
      mode_q      <= mode_d;
    end
  end

  assign tr.left      = left_q;
  assign tr.right     = right_q;
  assign tr.busy      = busy_q;
  assign tr.mode      = mode_q;
  assign tr.blink_cnt = blink_q;

endmodule

// File: tb/tb_turn_request_ctrl.sv
// Randomised and directed bench for turn_request_ctrl against a window-based
// behavioural model, with a simple sequencer driving seq_idle.
module tb_turn_request_ctrl;
  localparam int unsigned DEB  = 4;
  localparam int unsigned TAP  = 16;
  localparam int unsigned LANE = 3;
  localparam int unsigned CW   = 5;
  localparam int          MAXC = (1 << CW) - 1;

  logic div_clk = 1'b0;
  logic rst     = 1'b0;

  turn_request_if #(.CNT_W(CW)) tif ();

  turn_request_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .TAP_MAX_CYCLES (TAP),
    .LANE_BLINKS    (LANE),
    .CNT_W          (CW)
  ) dut (
    .div_clk(div_clk),
    .rst    (rst),
    .tr     (tif)
  );

  always #5 div_clk = ~div_clk;

  int tests = 0;
  int fails = 0;
  int seq_len_cfg = 3;
  int seq_rem = 0;
  int seq_starts = 0;

  // Model state: raw history feeding a window of synchronised samples.
  bit m_rh  [2][2];
  bit m_win [2][DEB];
  bit m_db  [2];
  bit m_prev_idle;
  int m_phase;   // 0 idle, 1 press, 2 hold, 3 lane
  int m_side;    // 0 left, 1 right
  int m_hold;
  int m_blinks;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rh[i][0] = 1'b0;
      m_rh[i][1] = 1'b0;
      m_db[i]    = 1'b0;
      for (int k = 0; k < DEB; k++) m_win[i][k] = 1'b0;
    end
    m_prev_idle = 1'b0;
    m_phase     = 0;
    m_side      = 0;
    m_hold      = 0;
    m_blinks    = 0;
  endtask

  task automatic model_step();
    bit start, own, oth, s, all_opp;
    bit raw [2];
    int nb;
    raw[0] = tif.left_sw;
    raw[1] = tif.right_sw;
    start  = m_prev_idle && !tif.seq_idle;
    if (m_phase == 0) begin
      if (m_db[0] != m_db[1]) begin
        m_side   = m_db[0] ? 0 : 1;
        m_phase  = 1;
        m_hold   = 0;
        m_blinks = 0;
      end
    end else begin
      own = m_db[m_side];
      oth = m_db[1 - m_side];
      nb  = (start && m_blinks < MAXC) ? m_blinks + 1 : m_blinks;
      if (oth) m_phase = 0;
      else if (m_phase == 1) begin
        if (!own) m_phase = 3;
        else begin
          m_hold++;
          if (m_hold == TAP) m_phase = 2;
        end
      end else if (m_phase == 2) begin
        if (!own) m_phase = 0;
      end else if (own) begin
        m_phase = 1;
        m_hold  = 0;
        nb      = 0;
      end else if ((start && m_blinks + 1 >= LANE) || m_blinks >= LANE) begin
        m_phase = 0;
      end
      m_blinks = nb;
    end
    // Debounced value flips once the last DEB synchronised samples all disagree.
    for (int i = 0; i < 2; i++) begin
      s = m_rh[i][1];
      for (int k = DEB - 1; k > 0; k--) m_win[i][k] = m_win[i][k-1];
      m_win[i][0] = s;
      all_opp = 1'b1;
      for (int k = 0; k < DEB; k++) if (m_win[i][k] == m_db[i]) all_opp = 1'b0;
      if (all_opp) m_db[i] = !m_db[i];
      m_rh[i][1] = m_rh[i][0];
      m_rh[i][0] = raw[i];
    end
    m_prev_idle = tif.seq_idle;
  endtask

  initial forever begin
    @(posedge div_clk or posedge rst);
    if (rst) model_reset();
    else     model_step();
  end

  // Sequencer stand-in: runs one sequence of seq_len_cfg edges per sampled request.
  initial forever begin
    @(posedge div_clk or posedge rst);
    if (rst) begin
      tif.seq_idle <= 1'b1;
      seq_rem      <= 0;
    end else if (tif.seq_idle) begin
      if (tif.left || tif.right) begin
        tif.seq_idle <= 1'b0;
        seq_rem      <= ((seq_len_cfg > 0) ? seq_len_cfg : int'($urandom_range(1, 6))) - 1;
        seq_starts   <= seq_starts + 1;
      end
    end else if (seq_rem == 0) begin
      tif.seq_idle <= 1'b1;
    end else begin
      seq_rem <= seq_rem - 1;
    end
  end

  initial forever begin
    @(negedge div_clk);
    chk("cyc_left",  tif.left,      (m_phase != 0 && m_side == 0) ? 1 : 0);
    chk("cyc_right", tif.right,     (m_phase != 0 && m_side == 1) ? 1 : 0);
    chk("cyc_mode",  tif.mode,      m_phase);
    chk("cyc_blink", tif.blink_cnt, m_blinks);
    chk("cyc_busy",  tif.busy,      (m_phase != 0) ? 1 : 0);
    chk("cyc_both",  tif.left & tif.right, 0);
  end

  task automatic run_edges(int n, output bit saw_l, output bit saw_r,
                           output bit saw_hold, output bit saw_lane);
    saw_l = 0; saw_r = 0; saw_hold = 0; saw_lane = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge div_clk);
      if (tif.left)        saw_l    = 1;
      if (tif.right)       saw_r    = 1;
      if (tif.mode == 2'b10) saw_hold = 1;
      if (tif.mode == 2'b11) saw_lane = 1;
    end
  endtask

  task automatic edges_to_left(output int n);
    n = 0;
    do begin
      @(posedge div_clk);
      #1;
      n++;
    end while (!tif.left && n < 30);
  endtask

  task automatic wait_state(string name, int md, int bc, int limit);
    int n;
    n = 0;
    while (!(tif.mode == md && (bc < 0 || tif.blink_cnt == bc)) && n < limit) begin
      @(negedge div_clk);
      n++;
    end
    chk(name, (n < limit) ? 1 : 0, 1);
  endtask

  task automatic tap_left();
    int n;
    @(negedge div_clk);
    tif.left_sw = 1'b1;
    edges_to_left(n);
    chk("tap_latency", n, 7);
    @(negedge div_clk);
    tif.left_sw = 1'b0;
  endtask

  initial begin
    bit sl, sr, sh, sn;
    int n, base, len, bnc;
    bit lv, rv;
    tif.left_sw  = 1'b0;
    tif.right_sw = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge div_clk);
    rst = 1'b0;
    #1;
    chk("rst_left",  tif.left, 0);
    chk("rst_right", tif.right, 0);
    chk("rst_mode",  tif.mode, 0);
    chk("rst_blink", tif.blink_cnt, 0);
    chk("rst_busy",  tif.busy, 0);

    // Tap: exactly LANE sequences, then back to idle.
    seq_len_cfg = 3;
    base = seq_starts;
    tap_left();
    run_edges(40, sl, sr, sh, sn);
    chk("tap_lane_seen", sn, 1);
    chk("tap_starts", seq_starts - base, 3);
    chk("tap_blink", tif.blink_cnt, 3);
    chk("tap_mode_end", tif.mode, 0);

    // Hold.
    @(negedge div_clk);
    tif.left_sw = 1'b1;
    run_edges(40, sl, sr, sh, sn);
    chk("hold_seen", sh, 1);
    chk("hold_no_right", sr, 0);
    tif.left_sw = 1'b0;
    run_edges(30, sl, sr, sh, sn);
    chk("hold_mode_end", tif.mode, 0);

    // Bounce rejection and debounce boundary.
    tif.left_sw = 1'b1; @(negedge div_clk);
    tif.left_sw = 1'b0; @(negedge div_clk);
    tif.left_sw = 1'b1; @(negedge div_clk);
    tif.left_sw = 1'b0;
    run_edges(20, sl, sr, sh, sn);
    chk("bounce_reject", sl, 0);
    tif.left_sw = 1'b1;
    repeat (DEB - 1) @(negedge div_clk);
    tif.left_sw = 1'b0;
    run_edges(20, sl, sr, sh, sn);
    chk("deb_short", sl, 0);
    tif.left_sw = 1'b1;
    repeat (DEB) @(negedge div_clk);
    tif.left_sw = 1'b0;
    run_edges(60, sl, sr, sh, sn);
    chk("deb_exact", sl, 1);

    // Both stalks from idle.
    tif.left_sw = 1'b1; tif.right_sw = 1'b1;
    run_edges(20, sl, sr, sh, sn);
    chk("both_idle", sl | sr, 0);
    tif.left_sw = 1'b0; tif.right_sw = 1'b0;
    run_edges(20, sl, sr, sh, sn);

    // Right stalk cancels a lane change, then starts its own request.
    seq_len_cfg = 6;
    tap_left();
    wait_state("lane_b1_wait", 3, 1, 60);
    tif.right_sw = 1'b1;
    run_edges(12, sl, sr, sh, sn);
    chk("cancel_right", tif.right, 1);
    chk("cancel_mode", tif.mode, 1);
    tif.right_sw = 1'b0;
    run_edges(50, sl, sr, sh, sn);

    // Re-arm during lane change.
    tap_left();
    wait_state("lane_b2_wait", 3, 2, 60);
    tif.left_sw = 1'b1;
    repeat (6) @(negedge div_clk);
    tif.left_sw = 1'b0;
    run_edges(80, sl, sr, sh, sn);
    chk("rearm_blink", tif.blink_cnt, 3);
    chk("rearm_mode", tif.mode, 0);

    // Asynchronous reset in the middle of a hold.
    seq_len_cfg = 3;
    @(negedge div_clk);
    tif.left_sw = 1'b1;
    wait_state("hold_wait", 2, -1, 60);
    #2 rst = 1'b1;
    #1;
    chk("arst_left", tif.left, 0);
    chk("arst_right", tif.right, 0);
    chk("arst_mode", tif.mode, 0);
    chk("arst_blink", tif.blink_cnt, 0);
    @(negedge div_clk);
    rst = 1'b0;
    edges_to_left(n);
    chk("arst_relatency", n, 7);
    @(negedge div_clk);
    tif.left_sw = 1'b0;
    run_edges(30, sl, sr, sh, sn);

    // Random stalk activity with bounce, random sequence lengths and resets.
    seq_len_cfg = 0;
    repeat (90) begin
      len = $urandom_range(1, 45);
      bnc = $urandom_range(0, 4);
      lv  = 1'($urandom_range(0, 1));
      rv  = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < len; k++) begin
        @(negedge div_clk);
        if (k < bnc) begin
          tif.left_sw  = 1'($urandom_range(0, 1));
          tif.right_sw = 1'($urandom_range(0, 1));
        end else begin
          tif.left_sw  = lv;
          tif.right_sw = rv;
        end
      end
      if ($urandom_range(0, 14) == 0) begin
        #2 rst = 1'b1;
        @(negedge div_clk);
        rst = 1'b0;
      end
    end
    tif.left_sw  = 1'b0;
    tif.right_sw = 1'b0;
    run_edges(40, sl, sr, sh, sn);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
